// File: rtl/mc_datapath_regs.sv
// Register stage of the multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut
// plus the operand, memory-address and register-file write muxes around them.
module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [1:0]  PCSrc,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  Mem2Reg,
  input  logic [1:0]  RegDst,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic        zero,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] instr,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] srca,
  output logic [31:0] srcb
);

  logic [31:0] pc_q, instr_q, mdr_q, a_q, b_q, alu_out_q;
  logic [31:0] next_pc;
  logic [31:0] signimm, signimm_sl2;
  logic        pc_en;

  // A taken branch needs the ALU zero flag; an unconditional write ignores it.
  assign pc_en = PCWrite | (Branch & zero);

  assign signimm     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign signimm_sl2 = {signimm[29:0], 2'b00};

  // Next-PC select.
  always_comb begin
    next_pc = alu_result;
    unique case (PCSrc)
      2'b00: next_pc = alu_result;
      2'b01: next_pc = alu_out_q;
      2'b10: next_pc = {pc_q[31:28], instr_q[25:0], 2'b00};
      2'b11: next_pc = a_q;
      default: next_pc = alu_result;
    endcase
  end

  // Architectural and holding registers; reset overrides every enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      mdr_q     <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
    end else begin
      if (pc_en)   pc_q    <= next_pc;
      if (IRWrite) instr_q <= mem_rdata;
      mdr_q     <= mem_rdata;
      a_q       <= rf_rd1;
      b_q       <= rf_rd2;
      alu_out_q <= alu_result;
    end
  end

  // ALU operand B select.
  always_comb begin
    srcb = b_q;
    unique case (ALUSrcB)
      2'b00: srcb = b_q;
      2'b01: srcb = 32'd4;
      2'b10: srcb = signimm;
      2'b11: srcb = signimm_sl2;
      default: srcb = b_q;
    endcase
  end

  // Register-file write address and data selects.
  always_comb begin
    rf_wa = instr_q[20:16];
    rf_wd = alu_out_q;
    unique case (RegDst)
      2'd0: rf_wa = instr_q[20:16];
      2'd1: rf_wa = instr_q[15:11];
      2'd2: rf_wa = 5'd31;
      2'd3: rf_wa = 5'd0;
      default: rf_wa = instr_q[20:16];
    endcase
    // For jal, pc already holds PC+4 from the fetch state.
    unique case (Mem2Reg)
      2'd0: rf_wd = alu_out_q;
      2'd1: rf_wd = mdr_q;
      2'd2: rf_wd = pc_q;
      2'd3: rf_wd = 32'h0;
      default: rf_wd = alu_out_q;
    endcase
  end

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign mem_addr  = IorD ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_we    = MemWrite;
  assign srca      = ALUSrcA ? a_q : pc_q;
  assign Opcode    = instr_q[31:26];
  assign Funct     = instr_q[5:0];
  assign rf_ra1    = instr_q[25:21];
  assign rf_ra2    = instr_q[20:16];

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for the multi-cycle datapath register stage.
module tb_mc_datapath_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, zero;
  logic [1:0]  PCSrc, ALUSrcB, Mem2Reg, RegDst;
  logic [31:0] mem_rdata, alu_result, rf_rd1, rf_rd2;
  logic [31:0] pc, mem_addr, mem_wdata, instr, rf_wd, srca, srcb;
  logic        mem_we;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_datapath_regs dut (
    .clk(clk), .reset(reset), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .Mem2Reg(Mem2Reg), .RegDst(RegDst), .mem_rdata(mem_rdata),
    .alu_result(alu_result), .zero(zero), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .instr(instr), .Opcode(Opcode), .Funct(Funct), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .srca(srca), .srcb(srcb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    IorD = 0; MemWrite = 0; IRWrite = 0; PCWrite = 0; Branch = 0; zero = 0;
    PCSrc = 2'b00; ALUSrcA = 0; ALUSrcB = 2'b00; Mem2Reg = 2'd0; RegDst = 2'd0;
  endtask

  task automatic test_reset();
    idle_ctrl();
    reset = 1; PCWrite = 1; IRWrite = 1;
    mem_rdata = 32'hAAAA_5555; alu_result = 32'h1234; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    tick();
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want %h", instr, 32'h0); end
    n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_b got %h want %h", mem_wdata, 32'h0); end
    IorD = 1; ALUSrcA = 1; Mem2Reg = 2'd1; #1;
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_aluout got %h want %h", mem_addr, 32'h0); end
    n_vec++; if (srca !== 32'h0) begin n_err++; $display("FAIL reset_a got %h want %h", srca, 32'h0); end
    n_vec++; if (rf_wd !== 32'h0) begin n_err++; $display("FAIL reset_mdr got %h want %h", rf_wd, 32'h0); end
  endtask

  task automatic test_fetch();
    idle_ctrl();
    reset = 0; mem_rdata = 32'h8C22_0004; alu_result = 32'd4; IRWrite = 1; PCWrite = 1; #1;
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL fetch_addr got %h want %h", mem_addr, 32'h0); end
    tick();
    IRWrite = 0; PCWrite = 0;
    n_vec++; if (instr !== 32'h8C22_0004) begin n_err++; $display("FAIL fetch_ir got %h want %h", instr, 32'h8C22_0004); end
    n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL fetch_pc got %h want %h", pc, 32'h4); end
    n_vec++; if (Opcode !== 6'h23) begin n_err++; $display("FAIL fetch_op got %h want %h", Opcode, 6'h23); end
    n_vec++; if (Funct !== 6'h04) begin n_err++; $display("FAIL fetch_funct got %h want %h", Funct, 6'h04); end
    n_vec++; if (rf_ra1 !== 5'd1 || rf_ra2 !== 5'd2) begin
      n_err++; $display("FAIL fetch_ra got %0d/%0d want 1/2", rf_ra1, rf_ra2); end
    // IR holds without IRWrite.
    mem_rdata = 32'hFFFF_FFFF; tick();
    n_vec++; if (instr !== 32'h8C22_0004) begin n_err++; $display("FAIL ir_hold got %h want %h", instr, 32'h8C22_0004); end
  endtask

  task automatic test_imm_mux();
    idle_ctrl();
    mem_rdata = 32'h2008_FFFC; IRWrite = 1; rf_rd1 = 32'd7; rf_rd2 = 32'd9; tick();
    IRWrite = 0;
    ALUSrcB = 2'b10; #1;
    n_vec++; if (srcb !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL srcb_imm got %h want %h", srcb, 32'hFFFF_FFFC); end
    ALUSrcB = 2'b11; #1;
    n_vec++; if (srcb !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL srcb_sl2 got %h want %h", srcb, 32'hFFFF_FFF0); end
    ALUSrcB = 2'b01; #1;
    n_vec++; if (srcb !== 32'd4) begin n_err++; $display("FAIL srcb_4 got %h want %h", srcb, 32'd4); end
    ALUSrcB = 2'b00; #1;
    n_vec++; if (srcb !== 32'd9) begin n_err++; $display("FAIL srcb_b got %h want %h", srcb, 32'd9); end
    ALUSrcA = 1; #1;
    n_vec++; if (srca !== 32'd7) begin n_err++; $display("FAIL srca_a got %h want %h", srca, 32'd7); end
    ALUSrcA = 0; #1;
    n_vec++; if (srca !== 32'h4) begin n_err++; $display("FAIL srca_pc got %h want %h", srca, 32'h4); end
    RegDst = 2'd0; #1;
    n_vec++; if (rf_wa !== 5'd8) begin n_err++; $display("FAIL wa_rt got %0d want %0d", rf_wa, 8); end
    RegDst = 2'd1; #1;
    n_vec++; if (rf_wa !== 5'd31) begin n_err++; $display("FAIL wa_rd got %0d want %0d", rf_wa, 31); end
    RegDst = 2'd3; #1;
    n_vec++; if (rf_wa !== 5'd0) begin n_err++; $display("FAIL wa_zero got %0d want %0d", rf_wa, 0); end
    Mem2Reg = 2'd3; #1;
    n_vec++; if (rf_wd !== 32'h0) begin n_err++; $display("FAIL wd_zero got %h want %h", rf_wd, 32'h0); end
  endtask

  task automatic test_branch();
    idle_ctrl();
    alu_result = 32'h40; tick();
    Branch = 1; PCSrc = 2'b01; zero = 0; tick();
    n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL br_not_taken got %h want %h", pc, 32'h4); end
    zero = 1; tick();
    n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL br_taken got %h want %h", pc, 32'h40); end
    // PCWrite overrides a false zero flag.
    zero = 0; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h44; tick();
    n_vec++; if (pc !== 32'h44) begin n_err++; $display("FAIL pcw_br got %h want %h", pc, 32'h44); end
  endtask

  task automatic test_jump();
    idle_ctrl();
    PCWrite = 1; alu_result = 32'h1000_0008; IRWrite = 1; mem_rdata = 32'h0C00_0010; tick();
    IRWrite = 0;
    PCSrc = 2'b10; RegDst = 2'd2; Mem2Reg = 2'd2; #1;
    n_vec++; if (rf_wa !== 5'd31) begin n_err++; $display("FAIL jal_wa got %0d want %0d", rf_wa, 31); end
    n_vec++; if (rf_wd !== 32'h1000_0008) begin n_err++; $display("FAIL jal_wd got %h want %h", rf_wd, 32'h1000_0008); end
    tick();
    n_vec++; if (pc !== 32'h1000_0040) begin n_err++; $display("FAIL jump_pc got %h want %h", pc, 32'h1000_0040); end
    PCWrite = 0; rf_rd1 = 32'h80; tick();
    PCWrite = 1; PCSrc = 2'b11; tick();
    PCWrite = 0;
    n_vec++; if (pc !== 32'h80) begin n_err++; $display("FAIL jr_pc got %h want %h", pc, 32'h80); end
  endtask

  task automatic test_ldst();
    idle_ctrl();
    mem_rdata = 32'h8C22_0004; IRWrite = 1; alu_result = 32'h104; rf_rd2 = 32'hDEAD_BEEF; tick();
    IRWrite = 0; IorD = 1; MemWrite = 1; #1;
    n_vec++; if (mem_addr !== 32'h104) begin n_err++; $display("FAIL st_addr got %h want %h", mem_addr, 32'h104); end
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL st_we got %b want 1", mem_we); end
    n_vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_data got %h want %h", mem_wdata, 32'hDEAD_BEEF); end
    MemWrite = 0; #1;
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL we_low got %b want 0", mem_we); end
    mem_rdata = 32'h55; tick();
    Mem2Reg = 2'd1; RegDst = 2'd0; #1;
    n_vec++; if (rf_wd !== 32'h55) begin n_err++; $display("FAIL ld_wd got %h want %h", rf_wd, 32'h55); end
    n_vec++; if (rf_wa !== 5'd2) begin n_err++; $display("FAIL ld_wa got %0d want %0d", rf_wa, 2); end
    Mem2Reg = 2'd0; #1;
    n_vec++; if (rf_wd !== 32'h104) begin n_err++; $display("FAIL wd_aluout got %h want %h", rf_wd, 32'h104); end
  endtask

  task automatic test_reset_mid();
    idle_ctrl();
    reset = 1; PCWrite = 1; IRWrite = 1; Branch = 1; zero = 1;
    mem_rdata = 32'h1357_9BDF; alu_result = 32'h2468; rf_rd1 = 32'h33; rf_rd2 = 32'h44;
    tick();
    reset = 0; PCWrite = 0; IRWrite = 0; Branch = 0;
    IorD = 1; ALUSrcA = 1; Mem2Reg = 2'd1; #1;
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL mid_pc got %h want %h", pc, 32'h0); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL mid_instr got %h want %h", instr, 32'h0); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL mid_aluout got %h want %h", mem_addr, 32'h0); end
    n_vec++; if (rf_wd !== 32'h0) begin n_err++; $display("FAIL mid_mdr got %h want %h", rf_wd, 32'h0); end
    n_vec++; if (srca !== 32'h0) begin n_err++; $display("FAIL mid_a got %h want %h", srca, 32'h0); end
    n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL mid_b got %h want %h", mem_wdata, 32'h0); end
  endtask

  initial begin
    idle_ctrl();
    reset = 1; mem_rdata = 0; alu_result = 0; rf_rd1 = 0; rf_rd2 = 0;
    test_reset();
    test_fetch();
    test_imm_mux();
    test_branch();
    test_jump();
    test_ldst();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
